// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-port input stage with per-VC circular FIFOs, round-robin head selection and batched credit return.
// Optional feature macro: INPUT_BUFFER_STATS_EN (adds max_occupancy and drop_count outputs).
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   in_valid/in_vc/in_flit   incoming flit from the link
//   out_valid/out_vc/out_flit  head flit presented to the crossbar
//   pop                 crossbar consumed the presented flit
//   credit_granted      one-cycle credit pulse per VC to the upstream sender
//   overflow_err        sticky: push to a full VC was dropped
//   underflow_err       sticky: pop while nothing was presented
//   max_occupancy       (stats) per-VC high-water mark of the fill count
//   drop_count          (stats) saturating count of dropped pushes
module vc_input_buffer #(
  parameter int NUM_VCS = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_WIDTH = 64,
  parameter int CREDIT_BATCH = 1,
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  input  logic [VW-1:0]          in_vc,
  input  logic [FLIT_WIDTH-1:0]  in_flit,
  output logic                   out_valid,
  output logic [VW-1:0]          out_vc,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  input  logic                   pop,
  output logic [NUM_VCS-1:0]     credit_granted,
  output logic                   overflow_err,
`ifdef INPUT_BUFFER_STATS_EN
  output logic                   underflow_err,
  output logic [NUM_VCS-1:0][CW-1:0] max_occupancy,
  output logic [15:0]            drop_count
`else
  output logic                   underflow_err
`endif
);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int BW = $clog2(CREDIT_BATCH + 1);
  logic [FLIT_WIDTH-1:0] mem_q [NUM_VCS][BUFFER_SIZE];
  logic [PW-1:0] wr_q [NUM_VCS];
  logic [PW-1:0] wr_d [NUM_VCS];
  logic [PW-1:0] rd_q [NUM_VCS];
  logic [PW-1:0] rd_d [NUM_VCS];
  logic [CW-1:0] cnt_q [NUM_VCS];
  logic [CW-1:0] cnt_d [NUM_VCS];
  logic [BW-1:0] pc_q [NUM_VCS];
  logic [BW-1:0] pc_d [NUM_VCS];
  logic [VW-1:0] cur_q, cur_d;
  logic [NUM_VCS-1:0] credit_q, credit_d;
  logic [NUM_VCS-1:0] psh, pp, last;
  logic ovf_q, unf_q;
  logic pop_ok, push_ok, drop, found;
  int idx;
  always_comb begin
    out_valid = cnt_q[cur_q] != '0;
    out_vc = cur_q;
    out_flit = out_valid ? mem_q[cur_q][rd_q[cur_q]] : '0;
    pop_ok = pop & out_valid;
    // a full VC still accepts a push when the same cycle frees one of its slots
    push_ok = in_valid & ((cnt_q[in_vc] != CW'(BUFFER_SIZE)) | (pop_ok & (cur_q == in_vc)));
    drop = in_valid & ~push_ok;
  end
  always_comb begin
    psh = '0;
    pp = '0;
    last = '0;
    credit_d = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      psh[v] = push_ok && (in_vc == VW'(v));
      pp[v] = pop_ok && (cur_q == VW'(v));
      wr_d[v] = psh[v] ? wr_q[v] + PW'(1) : wr_q[v];
      rd_d[v] = pp[v] ? rd_q[v] + PW'(1) : rd_q[v];
      cnt_d[v] = cnt_q[v] + CW'(psh[v]) - CW'(pp[v]);
      last[v] = pp[v] && (pc_q[v] == BW'(CREDIT_BATCH - 1));
      pc_d[v] = last[v] ? '0 : pc_q[v] + BW'(pp[v]);
      credit_d[v] = last[v];
    end
  end
  // round-robin: hold the presented VC until consumed, then scan from cur+1 wrapping back to cur
  always_comb begin
    cur_d = cur_q;
    found = 1'b0;
    idx = 0;
    if (!out_valid || pop) begin
      for (int i = 1; i <= NUM_VCS; i++) begin
        idx = (int'(cur_q) + i) % NUM_VCS;
        if (!found && cnt_d[idx] != '0) begin
          cur_d = VW'(idx);
          found = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q <= '{default: '0};
      rd_q <= '{default: '0};
      cnt_q <= '{default: '0};
      pc_q <= '{default: '0};
      cur_q <= '0;
      credit_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      cur_q <= cur_d;
      credit_q <= credit_d;
      ovf_q <= ovf_q | drop;
      unf_q <= unf_q | (pop & ~out_valid);
    end
  end
  // flit storage needs no reset: pointers and counts gate every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[in_vc][wr_q[in_vc]] <= in_flit;
  end
  assign credit_granted = credit_q;
  assign overflow_err = ovf_q;
  assign underflow_err = unf_q;
`ifdef INPUT_BUFFER_STATS_EN
  logic [NUM_VCS-1:0][CW-1:0] max_q;
  logic [15:0] drop_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      max_q <= '0;
      drop_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) max_q[v] <= (cnt_q[v] > max_q[v]) ? cnt_q[v] : max_q[v];
      drop_q <= (drop && drop_q != '1) ? drop_q + 16'd1 : drop_q;
    end
  end
  assign max_occupancy = max_q;
  assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: directed self-checking bench; dut uses CREDIT_BATCH=1, dut6 shares its inputs with CREDIT_BATCH=6.
module tb_vc_input_buffer;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic in_valid = 1'b0;
  logic [0:0] in_vc = '0;
  logic [63:0] in_flit = '0;
  logic pop = 1'b0;
  logic out_valid, out_valid6;
  logic [0:0] out_vc, out_vc6;
  logic [63:0] out_flit, out_flit6;
  logic [1:0] cg, cg6;
  logic oe, oe6, ue, ue6;
`ifdef INPUT_BUFFER_STATS_EN
  logic [1:0][3:0] mo, mo6;
  logic [15:0] dc, dc6;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vc_input_buffer #(.NUM_VCS(2), .BUFFER_SIZE(8), .FLIT_WIDTH(64), .CREDIT_BATCH(1)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit), .pop(pop),
    .credit_granted(cg), .overflow_err(oe),
`ifdef INPUT_BUFFER_STATS_EN
    .underflow_err(ue), .max_occupancy(mo), .drop_count(dc)
`else
    .underflow_err(ue)
`endif
  );
  vc_input_buffer #(.NUM_VCS(2), .BUFFER_SIZE(8), .FLIT_WIDTH(64), .CREDIT_BATCH(6)) dut6 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .out_valid(out_valid6), .out_vc(out_vc6), .out_flit(out_flit6), .pop(pop),
    .credit_granted(cg6), .overflow_err(oe6),
`ifdef INPUT_BUFFER_STATS_EN
    .underflow_err(ue6), .max_occupancy(mo6), .drop_count(dc6)
`else
    .underflow_err(ue6)
`endif
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    in_valid = 1'b1;
    pop = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_flit !== 64'h0) begin errors++; $display("FAIL reset_flit: got %h exp 0", out_flit); end
    checks++; if (out_vc !== 1'b0) begin errors++; $display("FAIL reset_vc: got %b exp 0", out_vc); end
    checks++; if (cg !== 2'b00) begin errors++; $display("FAIL reset_credit: got %b exp 00", cg); end
    cyc();
    checks++; if ({oe, ue} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b exp 00", {oe, ue}); end
    checks++; if (out_valid6 !== 1'b0) begin errors++; $display("FAIL reset_valid6: got %b exp 0", out_valid6); end
    in_valid = 1'b0;
    pop = 1'b0;
    n_rst = 1'b1;
  endtask
  task automatic test_single();
    in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'hA;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_not_comb: got %b exp 0", out_valid); end
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    checks++; if (out_vc !== 1'b0) begin errors++; $display("FAIL single_vc: got %b exp 0", out_vc); end
    checks++; if (out_flit !== 64'hA) begin errors++; $display("FAIL single_flit: got %h exp a", out_flit); end
    checks++; if (cg !== 2'b00) begin errors++; $display("FAIL single_credit_early: got %b exp 00", cg); end
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b exp 0", out_valid); end
    checks++; if (out_flit !== 64'h0) begin errors++; $display("FAIL single_flit_zero: got %h exp 0", out_flit); end
    checks++; if (cg !== 2'b01) begin errors++; $display("FAIL single_credit: got %b exp 01", cg); end
    cyc();
    checks++; if (cg !== 2'b00) begin errors++; $display("FAIL single_credit_once: got %b exp 00", cg); end
  endtask
  task automatic test_round_robin();
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_vc = (i < 4) ? 1'b0 : 1'b1;
      in_flit = ((i < 4) ? 64'h10 : 64'h1C) + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = ((i % 2 == 0) ? 64'h10 : 64'h20) + 64'(i / 2);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b exp 1", i, out_valid); end
      checks++; if (out_flit !== e) begin errors++; $display("FAIL rr_flit[%0d]: got %h exp %h", i, out_flit, e); end
      checks++; if (out_vc !== 1'(i % 2)) begin errors++; $display("FAIL rr_vc[%0d]: got %b exp %0d", i, out_vc, i % 2); end
      if (i > 0) begin
        checks++; if (cg !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_credit[%0d]: got %b", i, cg); end
      end
      cyc();
    end
    pop = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b exp 0", out_valid); end
    checks++; if (cg !== 2'b10) begin errors++; $display("FAIL rr_last_credit: got %b exp 10", cg); end
  endtask
  task automatic test_overflow();
    logic [63:0] e;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b exp 0", oe); end
      end
      in_valid = 1'b1; in_vc = 1'b1; in_flit = 64'h30 + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", oe); end
    checks++; if (out_vc !== 1'b1) begin errors++; $display("FAIL ovf_vc: got %b exp 1", out_vc); end
    checks++; if (out_flit !== 64'h30) begin errors++; $display("FAIL ovf_head: got %h exp 30", out_flit); end
    pop = 1'b1; in_valid = 1'b1; in_vc = 1'b1; in_flit = 64'h99;
    cyc();
    in_valid = 1'b0;
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", oe); end
    checks++; if (ue !== 1'b0) begin errors++; $display("FAIL ovf_no_unf: got %b exp 0", ue); end
    for (int k = 0; k < 8; k++) begin
      e = (k < 7) ? 64'h31 + 64'(k) : 64'h99;
      checks++; if (out_valid !== 1'b1 || out_flit !== e) begin errors++; $display("FAIL ovf_drain[%0d]: got %b/%h exp 1/%h", k, out_valid, out_flit, e); end
      cyc();
    end
    pop = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b exp 0", out_valid); end
  endtask
  task automatic test_underflow_and_reset();
    checks++; if (ue !== 1'b0) begin errors++; $display("FAIL unf_before: got %b exp 0", ue); end
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (ue !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b exp 1", ue); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unf_valid: got %b exp 0", out_valid); end
    checks++; if (cg !== 2'b00) begin errors++; $display("FAIL unf_credit: got %b exp 00", cg); end
    in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h55;
    cyc();
    in_flit = 64'h56;
    cyc();
    in_valid = 1'b0;
    checks++; if (out_vc !== 1'b0 || out_flit !== 64'h55) begin errors++; $display("FAIL unf_counts: got vc %b flit %h exp 0/55", out_vc, out_flit); end
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_flit !== 64'h56 || cg !== 2'b01) begin errors++; $display("FAIL pre_reset: got %b/%h/%b exp 1/56/01", out_valid, out_flit, cg); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_flit !== 64'h0) begin errors++; $display("FAIL midrst_out: got %b/%h exp 0/0", out_valid, out_flit); end
    checks++; if (cg !== 2'b00) begin errors++; $display("FAIL midrst_credit: got %b exp 00", cg); end
    checks++; if ({oe, ue} !== 2'b00) begin errors++; $display("FAIL midrst_errs: got %b exp 00", {oe, ue}); end
    checks++; if (out_valid6 !== 1'b0 || cg6 !== 2'b00) begin errors++; $display("FAIL midrst_dut6: got %b/%b exp 0/00", out_valid6, cg6); end
    cyc();
    n_rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_empty: got %b exp 0", out_valid); end
  endtask
  task automatic test_credit_batch();
    logic [1:0] e6;
    in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h100;
    cyc();
    for (int k = 1; k <= 18; k++) begin
      pop = 1'b1;
      in_valid = (k < 18);
      in_flit = 64'h100 + 64'(k);
      cyc();
      e6 = (k % 6 == 0) ? 2'b01 : 2'b00;
      checks++; if (cg6 !== e6) begin errors++; $display("FAIL batch6_credit[%0d]: got %b exp %b", k, cg6, e6); end
      checks++; if (cg !== 2'b01) begin errors++; $display("FAIL batch1_credit[%0d]: got %b exp 01", k, cg); end
    end
    pop = 1'b0;
    in_valid = 1'b0;
    cyc();
    checks++; if (cg6 !== 2'b00 || cg !== 2'b00) begin errors++; $display("FAIL batch_idle: got %b/%b exp 00/00", cg6, cg); end
    checks++; if (out_valid6 !== 1'b0) begin errors++; $display("FAIL batch_empty: got %b exp 0", out_valid6); end
  endtask
`ifdef INPUT_BUFFER_STATS_EN
  task automatic test_stats();
    #1 n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h200 + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    pop = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    pop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h300 + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    checks++; if (mo[0] !== 4'd5) begin errors++; $display("FAIL stats_max0: got %0d exp 5", mo[0]); end
    checks++; if (mo[1] !== 4'd0) begin errors++; $display("FAIL stats_max1_idle: got %0d exp 0", mo[1]); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_vc = 1'b1; in_flit = 64'h400 + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (dc !== 16'd2) begin errors++; $display("FAIL stats_drops: got %0d exp 2", dc); end
    checks++; if (mo[1] !== 4'd8) begin errors++; $display("FAIL stats_max1: got %0d exp 8", mo[1]); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_underflow_and_reset();
    test_credit_batch();
`ifdef INPUT_BUFFER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
